seq_detect_scheduler: RTL and testbench
=======================================

// Module: seq_detect_scheduler
// PURPOSE
//  Shares one "1-then-0" Moore detection engine among N_CH serial bit-stream requesters.
//  Keeps a saved 2-bit detector state per channel and grants one channel per cycle,
//  round-robin, over a valid/ready handshake.
//  Emits a registered per-transfer result and keeps saturating per-channel match counters.
//  Sits between the serial front-ends and the event/status logic.
// PARAMETERS
//  N_CH   4  number of requester channels (>=2); CH_W = $clog2(N_CH) is a localparam
//  CNT_W  8  width of each per-channel saturating match counter
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           reset, asynchronous, active-high
//  en         in   1           global enable; 0 = no grants, all state holds
//  clr_ch     in   N_CH        per-channel clear: state->S0, counter->0
//  req_valid  in   N_CH        channel i presents a bit
//  req_bit    in   N_CH        bit offered by channel i
//  req_ready  out  N_CH        one-hot-or-zero grant (combinational)
//  res_valid  out  1           result valid (1 cycle after transfer)
//  res_ch     out  CH_W        channel index of the result
//  res_match  out  1           1 = the transfer moved that channel into S2
//  match_cnt  out  N_CH*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset values: every channel state S0, rr_ptr 0, res_valid 0, res_ch 0, res_match 0,
//    all match_cnt 0. req_ready is 0 while rst is high.
//  - Detector table (per channel, Moore):
//      S0=00: bit1->S1, bit0->S0
//      S1=01: bit1->S1, bit0->S2
//      S2=10: bit1->S1, bit0->S0
//      11 (illegal): ->S0
//    Detector output = (state==S2).
//  - Eligible channel: req_valid[i] & en & ~clr_ch[i].
//  - Grant: the first eligible channel scanning from rr_ptr upward, wrapping modulo N_CH.
//    req_ready holds exactly that bit; it is all-zero if no channel is eligible.
//  - Transfer: req_valid[g] & req_ready[g]. On the same posedge:
//      st[g] <= next(st[g], req_bit[g])
//      rr_ptr <= (g+1) mod N_CH
//  - rr_ptr holds when there is no transfer.
//  - Result stage, one register, latency 1:
//      res_valid <= transfer
//      res_ch <= g
//      res_match <= (next state == S2)
//    res_ch and res_match hold their last value when res_valid is 0.
//    There is no backpressure on results.
//  - match_cnt[g] increments on a transfer with next state S2 and saturates at 2^CNT_W-1.
//  - clr_ch[i] wins over a transfer on channel i. The channel is not granted that cycle,
//    so no result is produced. Other channels arbitrate normally.
//  - en=0: req_ready is 0 and rr_ptr holds. clr_ch still acts.
//  - rst asserted mid-operation: the in-flight result is dropped (res_valid->0) and all
//    state returns to reset values immediately.
//  - Channel state persists between grants. Interleaving never corrupts another channel.
// STRUCTURE
//  - Package seq_detect_pkg holds:
//      typedef enum logic [1:0] det_state_t {S0, S1, S2}
//      function det_next(det_state_t, logic)
//      function det_match(det_state_t)
//  - Sub-module rr_arbiter #(N_CH): inputs elig and advance; outputs grant one-hot,
//    grant_idx and any_grant; owns rr_ptr.
//  - Top level holds the state array, the counters and the result register.
// TESTING
//  1. Single channel 0 sends bits 1,0 with N_CH=4 -> second transfer gives
//     res_valid=1, res_ch=0, res_match=1 one cycle later; match_cnt[0]=1.
//  2. All 4 channels hold valid constantly -> grants follow 0,1,2,3,0,...;
//     req_ready is always one-hot.
//  3. Interleaving: ch1 sends 1, then ch2 sends 1,0, then ch1 sends 0 ->
//     ch2 matches, and ch1 matches on its own 0 (its state S1 was preserved).
//  4. clr_ch[2] asserted in the same cycle ch2 is the only valid channel ->
//     req_ready=0, no result, st[2]=S0; the next ch2 bit 0 gives res_match=0.
//  5. CNT_W=2: feed channel 3 the pattern "10" five times -> match_cnt[3]
//     saturates at 3 and stays there.
//  6. rst pulse while res_valid=1 and ch0 is in S1 -> outputs go to reset values
//     asynchronously; after release ch0 sends 0 -> res_match=0.

Source files
------------

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and detector functions for the time-shared "1-then-0" detector.
// The next-state and match functions are the single definition of the Moore table.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } det_state_t;

   // The unused encoding 2'b11 falls to the default arm, so a corrupted state recovers to S0.
   function automatic det_state_t det_next(det_state_t st, logic b);
      det_state_t nxt;
      case (st)
         S0:      nxt = b ? S1 : S0;
         S1:      nxt = b ? S1 : S2;
         S2:      nxt = b ? S1 : S0;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

   function automatic logic det_match(det_state_t st);
      return (st == S2);
   endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester/result bus between the serial front-ends and the shared detector.
// The master side is the front-end group; the slave side is the scheduler.
interface seq_detect_scheduler_if #(
   parameter int N_CH = 4
) ();
   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0] req_valid;
   logic [N_CH-1:0] req_bit;
   logic [N_CH-1:0] req_ready;
   logic            res_valid;
   logic [CH_W-1:0] res_ch;
   logic            res_match;

   modport master (
      output req_valid, req_bit,
      input  req_ready, res_valid, res_ch, res_match
   );

   modport slave (
      input  req_valid, req_bit,
      output req_ready, res_valid, res_ch, res_match
   );
endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible channel at or after rr_ptr, wrapping.
// rr_ptr moves to the slot after the winner only when advance is high.
module rr_arbiter #(
   parameter int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] elig,
   input  logic            advance,
   output logic [N_CH-1:0] grant,
   output logic [CH_W-1:0] grant_idx,
   output logic            any_grant
);
   localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

   logic [CH_W-1:0] rr_ptr;
   int              idx;

   // Scan from the farthest offset down so the nearest eligible channel is written last and wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int off = N_CH - 1; off >= 0; off--) begin
         idx = (int'(rr_ptr) + off) % N_CH;
         if (elig[idx]) begin
            grant_idx = CH_W'(idx);
            any_grant = 1'b1;
         end
      end
      grant = any_grant ? (N_CH'(1) << grant_idx) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One "1-then-0" Moore detector shared round-robin among N_CH serial requesters,
// with a saved state per channel, a one-deep result register and saturating match counters.
module seq_detect_scheduler
   import seq_detect_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [N_CH-1:0]         clr_ch,
   seq_detect_scheduler_if.slave   bus,
   output logic [N_CH*CNT_W-1:0]   match_cnt
);
   localparam int CH_W = $clog2(N_CH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   det_state_t       st  [N_CH];
   logic [CNT_W-1:0] cnt [N_CH];

   logic [N_CH-1:0] elig;
   logic [N_CH-1:0] grant;
   logic [CH_W-1:0] grant_idx;
   logic            any_grant;
   det_state_t      nxt_g;

   // A clear on a channel removes it from arbitration, so the clear always beats a transfer.
   assign elig = bus.req_valid & ~clr_ch & {N_CH{en & ~rst}};

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .elig      (elig),
      .advance   (any_grant),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign bus.req_ready = grant;
   assign nxt_g         = det_next(st[grant_idx], bus.req_bit[grant_idx]);

   always_comb begin
      match_cnt = '0;
      for (int i = 0; i < N_CH; i++) match_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the state/counter arrays are small flop banks, not RAM, so they take the async reset.
         for (int i = 0; i < N_CH; i++) begin
            st[i]  <= S0;
            cnt[i] <= '0;
         end
         bus.res_valid <= 1'b0;
         bus.res_ch    <= '0;
         bus.res_match <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clr_ch[i]) begin
               st[i]  <= S0;
               cnt[i] <= '0;
            end else if (grant[i]) begin
               st[i] <= nxt_g;
               if (det_match(nxt_g) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end
         end
         bus.res_valid <= any_grant;
         if (any_grant) begin
            bus.res_ch    <= grant_idx;
            bus.res_match <= det_match(nxt_g);
         end
      end
   end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler (N_CH=4, CNT_W=2 so saturation is reachable).
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_seq_detect_scheduler;
   localparam int N_CH  = 4;
   localparam int CNT_W = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  en  = 1'b1;
   logic [N_CH-1:0]       clr_ch = '0;
   logic [N_CH*CNT_W-1:0] match_cnt;

   int n_checks = 0;
   int n_errors = 0;

   seq_detect_scheduler_if #(.N_CH(N_CH)) bus ();

   seq_detect_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr_ch    (clr_ch),
      .bus       (bus),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int ch);
      return 32'(match_cnt[ch*CNT_W +: CNT_W]);
   endfunction

   // One single-channel transfer; checks the grant and the result one cycle later.
   task automatic xfer(input int ch, input logic b, input logic exp_m);
      bus.req_valid     = '0;
      bus.req_bit       = '0;
      bus.req_valid[ch] = 1'b1;
      bus.req_bit[ch]   = b;
      #1;
      check("ready", 32'(bus.req_ready), 32'(1) << ch);
      @(posedge clk); #1;
      check("res_valid", 32'(bus.res_valid), 32'd1);
      check("res_ch",    32'(bus.res_ch),    32'(ch));
      check("res_match", 32'(bus.res_match), 32'(exp_m));
      bus.req_valid = '0;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_bit   = '0;

      // Reset state: grants suppressed while rst is high even with requests pending.
      #2;
      bus.req_valid = '1;
      #1;
      check("rst_ready",     32'(bus.req_ready), 32'd0);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_cnt",       32'(match_cnt),     32'd0);
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // 1. Channel 0 sends 1,0 -> match on the second transfer.
      xfer(0, 1'b1, 1'b0);
      xfer(0, 1'b0, 1'b1);
      check("t1_cnt0", cnt_of(0), 32'd1);

      // 2. All channels valid: rr_ptr is 1 after test 1, so grants run 1,2,3,0,...
      bus.req_valid = '1;
      bus.req_bit   = '1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t2_onehot", 32'($countones(bus.req_ready)), 32'd1);
         check("t2_grant",  32'(bus.req_ready), 32'(1) << ((1 + k) % N_CH));
         @(posedge clk); #1;
         check("t2_res_ch", 32'(bus.res_ch), 32'((1 + k) % N_CH));
      end

      // Clear every channel while all request: no grant, counters to 0.
      clr_ch = '1;
      #1;
      check("clr_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("clr_res_valid", 32'(bus.res_valid), 32'd0);
      check("clr_cnt",       32'(match_cnt),     32'd0);
      clr_ch        = '0;
      bus.req_valid = '0;

      // 3. Interleaving: ch1's S1 survives ch2's 1,0.
      xfer(1, 1'b1, 1'b0);
      xfer(2, 1'b1, 1'b0);
      xfer(2, 1'b0, 1'b1);
      xfer(1, 1'b0, 1'b1);
      check("t3_cnt1", cnt_of(1), 32'd1);
      check("t3_cnt2", cnt_of(2), 32'd1);

      // 4. Clear beats a transfer on ch2; results hold their last values.
      bus.req_valid = 4'b0100;
      bus.req_bit   = 4'b0100;
      clr_ch        = 4'b0100;
      #1;
      check("t4_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("t4_res_valid", 32'(bus.res_valid), 32'd0);
      check("t4_res_ch",    32'(bus.res_ch),    32'd1);
      check("t4_res_match", 32'(bus.res_match), 32'd1);
      check("t4_cnt2",      cnt_of(2),          32'd0);
      clr_ch = '0;
      xfer(2, 1'b0, 1'b0);

      // en=0 blocks every grant.
      en            = 1'b0;
      bus.req_valid = '1;
      #1;
      check("en_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("en_res_valid", 32'(bus.res_valid), 32'd0);
      en            = 1'b1;
      bus.req_valid = '0;

      // 5. Channel 3 gets "10" five times; the 2-bit counter saturates at 3.
      for (int k = 1; k <= 5; k++) begin
         xfer(3, 1'b1, 1'b0);
         xfer(3, 1'b0, 1'b1);
         check("t5_cnt3", cnt_of(3), 32'((k > 3) ? 3 : k));
      end

      // 6. Async reset mid-operation: ch0 in S1, result for ch3 in flight.
      xfer(0, 1'b1, 1'b0);
      xfer(3, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("t6_res_valid", 32'(bus.res_valid), 32'd0);
      check("t6_res_ch",    32'(bus.res_ch),    32'd0);
      check("t6_res_match", 32'(bus.res_match), 32'd0);
      check("t6_cnt",       32'(match_cnt),     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
